keypad_scan_ctrl: RTL and testbench

- Sequencer for the 12-input keypad select mux (4-bit select in, one selected key line out).
- Steps the select code through indices 0..11, waits for the line to settle, then samples the mux output.
- Debounces each of the 12 keys independently and queues debounced press events as 4-bit key codes in a small FIFO with a valid/ready handshake.
- Sits between the keypad mux and the launchpad sound/LED logic.

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/key_fifo.sv | 51 +++++
 rtl/keypad_scan_ctrl.sv | 104 ++++++++++
 tb/tb_keypad_scan_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared key indices and code type for the keypad scanner.
// The index of each key is also the code it produces in the event FIFO.
package keypad_pkg;

    localparam int KEY_CNT = 12;

    typedef logic [3:0] key_code_t;

    localparam key_code_t KEY_D1    = 4'd0;
    localparam key_code_t KEY_D2    = 4'd1;
    localparam key_code_t KEY_D3    = 4'd2;
    localparam key_code_t KEY_D4    = 4'd3;
    localparam key_code_t KEY_D5    = 4'd4;
    localparam key_code_t KEY_D6    = 4'd5;
    localparam key_code_t KEY_D7    = 4'd6;
    localparam key_code_t KEY_D8    = 4'd7;
    localparam key_code_t KEY_D9    = 4'd8;
    localparam key_code_t KEY_STAR  = 4'd9;
    localparam key_code_t KEY_D0    = 4'd10;
    localparam key_code_t KEY_SHARP = 4'd11;

    // Select codes 12..15 are never produced; the scan wraps after sharp.
    function automatic key_code_t next_index(input key_code_t k);
        return (k == KEY_SHARP) ? KEY_D1 : k + 4'd1;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// First-word-fall-through sync FIFO with wrap-bit pointers.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             pop_ok, push_ok;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // Popping an empty FIFO is a no-op; popping a full one frees the slot for a same-cycle push.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign drop_o  = push_i & ~push_ok;

    assign wr_d   = wr_q + {{AW{1'b0}}, push_ok};
    assign rd_d   = rd_q + {{AW{1'b0}}, pop_ok};
    assign head_o = mem[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad mux sequencer: steps the select code, samples each key after settling,
// debounces all 12 keys and queues press events as key codes.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int DEB_SCANS  = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                scan_en,
    output logic [3:0]          B_sel,
    input  logic                D_in,
    output logic [3:0]          key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic [KEY_CNT-1:0]  keys_down,
    output logic                ovf,
    input  logic                ovf_clr
);
    localparam int SW = $clog2(SETTLE_CYC);
    localparam int DW = (DEB_SCANS > 1) ? $clog2(DEB_SCANS) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_SCANS - 1);

    key_code_t                   sel_q, sel_d;
    logic [SW-1:0]               settle_q, settle_d;
    logic [KEY_CNT-1:0]          keys_q, keys_d, hit, differ, flip;
    logic [KEY_CNT-1:0][DW-1:0]  cnt_q, cnt_d;
    logic                        sample, push, pop, ovf_q, ovf_d;
    logic                        fifo_full, fifo_empty, fifo_drop;
    key_code_t                   fifo_head;

    assign sample = scan_en && (settle_q == SETTLE_LAST);

    always_comb begin
        sel_d    = sel_q;
        settle_d = settle_q;
        if (scan_en) begin
            if (sample) begin
                settle_d = '0;
                sel_d    = next_index(sel_q);
            end else begin
                settle_d = settle_q + SW'(1);
            end
        end
    end

    // Only the key currently selected sees its sample; all others hold.
    for (genvar gi = 0; gi < KEY_CNT; gi++) begin : g_deb
        assign hit[gi]    = sample && (sel_q == key_code_t'(gi));
        assign differ[gi] = (D_in != keys_q[gi]);
        assign flip[gi]   = hit[gi] && differ[gi] && (cnt_q[gi] == DEB_LAST);
        assign keys_d[gi] = keys_q[gi] ^ flip[gi];
        assign cnt_d[gi]  = !hit[gi]                    ? cnt_q[gi] :
                            (!differ[gi] || flip[gi])   ? '0        :
                                                          cnt_q[gi] + DW'(1);
    end

    assign push = |(flip & keys_d);
    assign pop  = key_valid & key_ready;

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk         (CLK),
        .rst         (RST),
        .push_i      (push),
        .push_data_i (sel_q),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .drop_o      (fifo_drop)
    );

    // A fresh overflow outranks a coincident clear.
    assign ovf_d = (fifo_drop && fifo_full) ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sel_q    <= KEY_D1;
            settle_q <= '0;
            keys_q   <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            settle_q <= settle_d;
            keys_q   <= keys_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign B_sel     = sel_q;
    assign keys_down = keys_q;
    assign ovf       = ovf_q;
    assign key_valid = ~fifo_empty;
    assign key_code  = key_valid ? fifo_head : 4'd0;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: hand-computed phase table, an async reset sequence,
// then random key activity checked every cycle against a scan-level reference model.
module tb_keypad_scan_ctrl;
    localparam int S     = 4;
    localparam int DEB   = 3;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        scan_en, D_in, key_ready, ovf_clr;
    logic [3:0]  B_sel, key_code;
    logic        key_valid, ovf;
    logic [11:0] keys_down;
    logic [11:0] pressed;

    int n_err   = 0;
    int n_check = 0;

    keypad_scan_ctrl #(.SETTLE_CYC(S), .DEB_SCANS(DEB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .scan_en   (scan_en),
        .B_sel     (B_sel),
        .D_in      (D_in),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .keys_down (keys_down),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 CLK = ~CLK;

    // The keypad itself: the mux returns the pressed state of the selected key.
    assign D_in = (B_sel < 4'd12) ? pressed[B_sel] : 1'b0;

    // Reference model: t counts enabled cycles since reset; key (t/S)%12 is sampled
    // when t%S == S-1, a key flips after DEB consecutive disagreeing samples.
    int          m_t;
    bit [11:0]   m_keys;
    int          m_streak [12];
    int          m_q [$];
    bit          m_ovf;

    task automatic model_reset();
        m_t = 0;
        m_keys = '0;
        foreach (m_streak[i]) m_streak[i] = 0;
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_edge();
        bit push = 1'b0;
        bit drop = 1'b0;
        int code = 0;
        if (scan_en) begin
            if (m_t % S == S - 1) begin
                int idx = (m_t / S) % 12;
                bit s = pressed[idx];
                if (s == m_keys[idx]) begin
                    m_streak[idx] = 0;
                end else begin
                    m_streak[idx]++;
                    if (m_streak[idx] == DEB) begin
                        m_keys[idx] = s;
                        m_streak[idx] = 0;
                        if (s) begin
                            push = 1'b1;
                            code = idx;
                        end
                    end
                end
            end
            m_t++;
        end
        if (key_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(code);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_check++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_cycle();
        int exp_sel  = (m_t / S) % 12;
        int exp_code = (m_q.size() > 0) ? m_q[0] : 0;
        int exp_v    = (m_q.size() > 0) ? 1 : 0;
        chk("cycle{sel,valid,code,keys,ovf}",
            int'({B_sel, key_valid, key_code, keys_down, ovf}),
            int'({exp_sel[3:0], exp_v[0], exp_code[3:0], m_keys, m_ovf}));
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            model_edge();
            @(negedge CLK);
            check_cycle();
        end
    endtask

    typedef struct {
        logic [11:0] mask;
        bit          ready;
        bit          clr;
        int          ncyc;
        logic [11:0] e_keys;
        bit          e_valid;
        logic [3:0]  e_code;
        bit          e_ovf;
    } vec_t;

    vec_t tbl [17];

    initial begin
        // One scan = 48 cycles; phases keep scan alignment so expectations are easy to derive.
        tbl[0]  = '{12'h000, 0, 0,  48, 12'h000, 0, 4'd0,  0}; // idle scan
        tbl[1]  = '{12'h010, 0, 0, 144, 12'h010, 1, 4'd4,  0}; // D5 held 3 scans
        tbl[2]  = '{12'h010, 1, 0,  48, 12'h010, 0, 4'd0,  0}; // consume it
        tbl[3]  = '{12'h410, 0, 0,  96, 12'h010, 0, 4'd0,  0}; // D0 glitch 2 scans
        tbl[4]  = '{12'h010, 0, 0, 144, 12'h010, 0, 4'd0,  0}; // glitch released
        tbl[5]  = '{12'h000, 0, 0, 144, 12'h000, 0, 4'd0,  0}; // release D5: no event
        tbl[6]  = '{12'hA00, 0, 0, 144, 12'hA00, 1, 4'd9,  0}; // star then sharp
        tbl[7]  = '{12'h000, 0, 0, 144, 12'h000, 1, 4'd9,  0}; // releases: no events
        tbl[8]  = '{12'h000, 1, 0,   1, 12'h000, 1, 4'd11, 0}; // single pop
        tbl[9]  = '{12'h000, 0, 0,  47, 12'h000, 1, 4'd11, 0};
        tbl[10] = '{12'h000, 1, 0,  48, 12'h000, 0, 4'd0,  0};
        tbl[11] = '{12'h02F, 0, 0, 144, 12'h02F, 1, 4'd0,  1}; // five presses, fifth dropped
        tbl[12] = '{12'h02F, 0, 1,   1, 12'h02F, 1, 4'd0,  0}; // clear ovf
        tbl[13] = '{12'h000, 0, 0, 143, 12'h000, 1, 4'd0,  0};
        tbl[14] = '{12'h040, 0, 0, 123, 12'h000, 1, 4'd0,  0}; // up to D7's third sample
        tbl[15] = '{12'h040, 1, 0,   1, 12'h040, 1, 4'd1,  0}; // push+pop while full
        tbl[16] = '{12'h040, 0, 0,  24, 12'h040, 1, 4'd1,  0};

        RST = 1'b1;
        scan_en = 1'b0;
        key_ready = 1'b0;
        ovf_clr = 1'b0;
        pressed = '0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        check_cycle();
        RST = 1'b0;
        scan_en = 1'b1;

        for (int v = 0; v < 17; v++) begin
            pressed   = tbl[v].mask;
            key_ready = tbl[v].ready;
            ovf_clr   = tbl[v].clr;
            step(tbl[v].ncyc);
            chk($sformatf("vec%0d.keys", v),  int'(keys_down), int'(tbl[v].e_keys));
            chk($sformatf("vec%0d.valid", v), int'(key_valid), int'(tbl[v].e_valid));
            chk($sformatf("vec%0d.code", v),  int'(key_code),  int'(tbl[v].e_code));
            chk($sformatf("vec%0d.ovf", v),   int'(ovf),       int'(tbl[v].e_ovf));
        end

        // Leave two entries queued, then hit reset mid-settle.
        ovf_clr = 1'b0;
        key_ready = 1'b1;
        step(2);
        key_ready = 1'b0;
        step(2);
        chk("pre_rst.valid", int'(key_valid), 1);
        chk("pre_rst.code",  int'(key_code),  3);
        #2 RST = 1'b1;
        model_reset();
        #1;
        chk("rst_async.sel",   int'(B_sel),     0);
        chk("rst_async.valid", int'(key_valid), 0);
        chk("rst_async.code",  int'(key_code),  0);
        chk("rst_async.keys",  int'(keys_down), 0);
        chk("rst_async.ovf",   int'(ovf),       0);
        @(negedge CLK);
        check_cycle();
        RST = 1'b0;
        step(4);
        chk("rst_restart.sel", int'(B_sel), 1);
        step(44);

        // Random key activity, including glitches, stalls, pops and clears.
        for (int it = 0; it < 60; it++) begin
            int hold = $urandom_range(1, 200);
            pressed = 12'($urandom & $urandom & $urandom);
            for (int c = 0; c < hold; c++) begin
                scan_en   = ($urandom_range(0, 9) != 0);
                key_ready = ($urandom_range(0, 9) < 3);
                ovf_clr   = ($urandom_range(0, 19) == 0);
                step(1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_check);
        $finish;
    end

endmodule
